// File: rtl/dds_conf_decoder_mc.sv
// Multi-channel DDS configuration decoder: header/payload word stream into per-channel
// shadow registers, atomically committed to the active DDS outputs by a masked COMMIT.
module dds_conf_decoder_mc #(
  parameter int N_CH   = 4,
  parameter int FW     = 32,
  parameter int PW     = 12,
  parameter int TW     = 2,
  parameter int TO_CYC = 255
) (
  input  logic                 dds_clk,
  input  logic                 rst_n,
  input  logic [31:0]          cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 dds_work_flag,
  output logic [N_CH-1:0]      dds_en,
  output logic [N_CH-1:0]      set_flag,
  output logic [N_CH*FW-1:0]   f_word,
  output logic [N_CH*PW-1:0]   p_word,
  output logic [N_CH*TW-1:0]   wave_type,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int TMW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);

  typedef enum logic {S_HDR, S_PAY} state_t;

  state_t           state_q, state_d;
  logic             ready_q;
  logic [3:0]       pch_q, pch_d;
  logic [TMW-1:0]   timer_q, timer_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [N_CH-1:0]  set_flag_q, set_flag_d;
  logic [N_CH-1:0]  dds_en_q, dds_en_d;

  logic [FW-1:0]    sh_f_q [N_CH];
  logic [FW-1:0]    sh_f_d [N_CH];
  logic [PW-1:0]    sh_p_q [N_CH];
  logic [PW-1:0]    sh_p_d [N_CH];
  logic [TW-1:0]    sh_t_q [N_CH];
  logic [TW-1:0]    sh_t_d [N_CH];
  logic [N_CH-1:0]  sh_e_q, sh_e_d;

  logic [FW-1:0]    act_f_q [N_CH];
  logic [FW-1:0]    act_f_d [N_CH];
  logic [PW-1:0]    act_p_q [N_CH];
  logic [PW-1:0]    act_p_d [N_CH];
  logic [TW-1:0]    act_t_q [N_CH];
  logic [TW-1:0]    act_t_d [N_CH];
  logic [N_CH-1:0]  act_e_q, act_e_d;

  logic [3:0]       op;
  logic [3:0]       ch;
  logic [N_CH-1:0]  mask;
  logic             accept;
  logic             ch_ok;

  assign op     = cfg_data[31:28];
  assign ch     = cfg_data[27:24];
  assign mask   = cfg_data[N_CH-1:0];
  assign accept = cfg_valid & ready_q;
  assign ch_ok  = ({28'd0, ch} < 32'(N_CH));

  always_comb begin
    state_d    = state_q;
    pch_d      = pch_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    set_flag_d = '0;
    sh_f_d     = sh_f_q;
    sh_p_d     = sh_p_q;
    sh_t_d     = sh_t_q;
    sh_e_d     = sh_e_q;
    act_f_d    = act_f_q;
    act_p_d    = act_p_q;
    act_t_d    = act_t_q;
    act_e_d    = act_e_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (op >= 4'h1 && op <= 4'h4 && !ch_ok) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else begin
            case (op)
              4'h0: ;
              4'h1: begin
                state_d = S_PAY;
                pch_d   = ch;
                timer_d = '0;
              end
              4'h2: for (int i = 0; i < N_CH; i++)
                      if (ch == 4'(i)) sh_p_d[i] = cfg_data[PW-1:0];
              4'h3: for (int i = 0; i < N_CH; i++)
                      if (ch == 4'(i)) sh_t_d[i] = cfg_data[TW-1:0];
              4'h4: for (int i = 0; i < N_CH; i++)
                      if (ch == 4'(i)) sh_e_d[i] = cfg_data[0];
              4'h5: begin
                for (int i = 0; i < N_CH; i++) begin
                  if (mask[i]) begin
                    act_f_d[i] = sh_f_q[i];
                    act_p_d[i] = sh_p_q[i];
                    act_t_d[i] = sh_t_q[i];
                    act_e_d[i] = sh_e_q[i];
                  end
                end
                set_flag_d = mask;
              end
              default: begin
                err_d      = 1'b1;
                err_code_d = 2'd1;
              end
            endcase
          end
        end
      end
      S_PAY: begin
        // The payload word is raw data and never goes through the header decode.
        if (accept) begin
          for (int i = 0; i < N_CH; i++)
            if (pch_q == 4'(i)) sh_f_d[i] = cfg_data[FW-1:0];
          state_d = S_HDR;
        end else if (timer_q == TMW'(TO_CYC - 1)) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = S_HDR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase

    dds_en_d = act_e_d & {N_CH{dds_work_flag}};
  end

  always_ff @(posedge dds_clk) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      ready_q    <= 1'b0;
      pch_q      <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      set_flag_q <= '0;
      dds_en_q   <= '0;
      sh_e_q     <= '0;
      act_e_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_f_q[i]  <= '0;
        sh_p_q[i]  <= '0;
        sh_t_q[i]  <= '0;
        act_f_q[i] <= '0;
        act_p_q[i] <= '0;
        act_t_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      pch_q      <= pch_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      set_flag_q <= set_flag_d;
      dds_en_q   <= dds_en_d;
      sh_f_q     <= sh_f_d;
      sh_p_q     <= sh_p_d;
      sh_t_q     <= sh_t_d;
      sh_e_q     <= sh_e_d;
      act_f_q    <= act_f_d;
      act_p_q    <= act_p_d;
      act_t_q    <= act_t_d;
      act_e_q    <= act_e_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
      assign f_word[gi*FW +: FW]    = act_f_q[gi];
      assign p_word[gi*PW +: PW]    = act_p_q[gi];
      assign wave_type[gi*TW +: TW] = act_t_q[gi];
    end
  endgenerate

  assign cfg_ready = ready_q;
  assign dds_en    = dds_en_q;
  assign set_flag  = set_flag_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q == S_PAY);

endmodule

// File: tb/tb_dds_conf_decoder_mc.sv
// Directed bench for dds_conf_decoder_mc: hand-computed expectations, one line per check on mismatch.
module tb_dds_conf_decoder_mc;

  localparam int N_CH   = 4;
  localparam int FW     = 32;
  localparam int PW     = 12;
  localparam int TW     = 2;
  localparam int TO_CYC = 255;

  logic                dds_clk = 1'b0;
  logic                rst_n;
  logic [31:0]         cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
  logic                dds_work_flag;
  logic [N_CH-1:0]     dds_en;
  logic [N_CH-1:0]     set_flag;
  logic [N_CH*FW-1:0]  f_word;
  logic [N_CH*PW-1:0]  p_word;
  logic [N_CH*TW-1:0]  wave_type;
  logic                err;
  logic [1:0]          err_code;
  logic                busy;

  int total = 0;
  int bad   = 0;

  dds_conf_decoder_mc #(
    .N_CH(N_CH), .FW(FW), .PW(PW), .TW(TW), .TO_CYC(TO_CYC)
  ) dut (
    .dds_clk(dds_clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .dds_work_flag(dds_work_flag), .dds_en(dds_en),
    .set_flag(set_flag), .f_word(f_word), .p_word(p_word), .wave_type(wave_type),
    .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 dds_clk = ~dds_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; the word is taken at the next edge.
  task automatic send(input logic [31:0] w);
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(posedge dds_clk);
    #1;
    cfg_valid = 1'b0;
    cfg_data  = 32'h0;
    $display("word %08h accepted: set_flag=%b err=%b err_code=%0d busy=%b", w, set_flag, err, err_code, busy);
  endtask

  task automatic tick();
    @(posedge dds_clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_valid     = 1'b0;
    cfg_data      = 32'h0;
    dds_work_flag = 1'b1;

    // T1 reset
    repeat (3) tick();
    check("rst_ready", cfg_ready, 0);
    check("rst_f", f_word, 0);
    check("rst_p", p_word, 0);
    check("rst_t", wave_type, 0);
    check("rst_en", dds_en, 0);
    check("rst_flag", set_flag, 0);
    check("rst_err", {err, err_code, busy}, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", cfg_ready, 1);

    // T2 full configuration of channel 1
    send(32'h1100_0000);
    check("t2_busy_hdr", busy, 1);
    send(32'h0123_4567);
    check("t2_busy_pay", busy, 0);
    send(32'h2100_0800);
    send(32'h3100_0002);
    send(32'h4100_0001);
    check("t2_precommit_f", f_word, 0);
    check("t2_precommit_en", dds_en, 0);
    send(32'h5000_0002);
    check("t2_f", f_word, 128'h0000_0000_0000_0000_0123_4567_0000_0000);
    check("t2_p", p_word, 48'h0000_0080_0000);
    check("t2_t", wave_type, 8'b0000_1000);
    check("t2_en", dds_en, 4'b0010);
    check("t2_flag", set_flag, 4'b0010);
    tick();
    check("t2_flag_gone", set_flag, 0);

    // T3 shadow isolation
    send(32'h2100_0123);
    check("t3_p_hold", p_word, 48'h0000_0080_0000);
    send(32'h5000_000F);
    check("t3_p", p_word, 48'h0000_0012_3000);
    check("t3_flag", set_flag, 4'hF);
    check("t3_f_kept", f_word, 128'h0000_0000_0000_0000_0123_4567_0000_0000);
    check("t3_en", dds_en, 4'b0010);
    tick();
    check("t3_flag_gone", set_flag, 0);

    // T4 protocol errors
    send(32'h7000_0000);
    check("t4_op_err", {err, err_code}, {1'b1, 2'd1});
    tick();
    check("t4_err_pulse", {err, err_code}, {1'b0, 2'd1});
    send(32'h2500_0001);
    check("t4_ch_err", {err, err_code}, {1'b1, 2'd2});
    send(32'h1700_0000);
    check("t4_no_pay", busy, 0);
    send(32'h5000_000F);
    check("t4_p_kept", p_word, 48'h0000_0012_3000);
    check("t4_t_kept", wave_type, 8'b0000_1000);

    // T5 payload timeout, with a known committed f_word[0]
    send(32'h1000_0000);
    send(32'hAABB_CCDD);
    send(32'h5000_0001);
    check("t5_f0_set", f_word[31:0], 32'hAABB_CCDD);
    send(32'h1000_0000);
    repeat (TO_CYC - 1) tick();
    check("t5_before_to", {busy, err}, 2'b10);
    tick();
    check("t5_to", {busy, err, err_code}, {1'b0, 1'b1, 2'd3});
    send(32'h5000_0001);
    check("t5_f0_kept", f_word[31:0], 32'hAABB_CCDD);
    check("t5_no_err", err, 0);

    // T6 work-flag gating
    send(32'h4000_0001);
    send(32'h5000_0001);
    check("t6_en_on", dds_en, 4'b0011);
    dds_work_flag = 1'b0;
    check("t6_en_same_cycle", dds_en, 4'b0011);
    tick();
    check("t6_en_gated", dds_en, 4'b0000);
    send(32'h2000_0055);
    send(32'h5000_0001);
    check("t6_commit_gated", p_word[11:0], 12'h055);
    check("t6_en_still_off", dds_en, 4'b0000);
    dds_work_flag = 1'b1;
    tick();
    check("t6_en_back", dds_en, 4'b0011);

    // Reset while waiting for a payload aborts silently
    send(32'h1200_0000);
    check("rp_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("rp_abort", {busy, err, err_code, cfg_ready}, 0);
    check("rp_f", f_word, 0);
    rst_n = 1'b1;
    tick();
    check("rp_ready", cfg_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
